// File: rtl/pll_rst_pkg.sv
// Shared types and constants for the PLL lock supervisor: state encoding,
// default timing parameters and the shared-counter width helper.
package pll_rst_pkg;

  typedef enum logic [2:0] {
    PLL_RESET   = 3'd0,
    WAIT_LOCK   = 3'd1,
    STABLE_WAIT = 3'd2,
    RUN         = 3'd3,
    FAIL        = 3'd4
  } state_e;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 50000;
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_MAX_RETRY     = 8;

  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 8;
  localparam logic [LOSS_W-1:0] LOSS_MAX = '1;

  // One counter serves every timed state, so size it for the largest interval.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/pll_lock_rst_gen_if.sv
// Status/control bundle between the reset sequencer (master) and the PLL
// wrapper plus downstream reset consumers (slave).
interface pll_lock_rst_gen_if;
  import pll_rst_pkg::*;

  logic               pll_lock;
  logic               pll_rst;
  logic               user_rst;
  logic               ready;
  logic               pll_fail;
  logic [RETRY_W-1:0] retry_cnt;
  logic [LOSS_W-1:0]  loss_cnt;

  modport master (
    input  pll_lock,
    output pll_rst,
    output user_rst,
    output ready,
    output pll_fail,
    output retry_cnt,
    output loss_cnt
  );

  modport slave (
    output pll_lock,
    input  pll_rst,
    input  user_rst,
    input  ready,
    input  pll_fail,
    input  retry_cnt,
    input  loss_cnt
  );
endinterface

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer; 2 clk cycles of latency, no backpressure.
// Both flops clear to 0 under the synchronous reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_rst_gen.sv
// PLL lock supervisor/reset sequencer: outputs registered off the next state,
// lock-loss reaches user_rst 3 edges after pll_lock falls; no backpressure.
module pll_lock_rst_gen
  import pll_rst_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRY     = DEF_MAX_RETRY
) (
  input  logic               clk,
  input  logic               rst,
  pll_lock_rst_gen_if.master bus
);

  localparam int CNT_W = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, MAX_RETRY);

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRY);

  logic lock_s;

  state_e             state_q,  state_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic [RETRY_W-1:0] retry_q,  retry_d;
  logic [LOSS_W-1:0]  loss_q,   loss_d;
  logic               pll_rst_q, user_rst_q, ready_q, fail_q;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d_i (bus.pll_lock),
    .q_o (lock_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    case (state_q)
      PLL_RESET: begin
        if (cnt_q == RST_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Lock is checked before the timeout so a late lock still wins.
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          cnt_d = '0;
          if (retry_q == RETRY_MAX) begin
            state_d = FAIL;
          end else begin
            retry_d = retry_q + RETRY_W'(1);
            state_d = PLL_RESET;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STABLE_WAIT: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // A lock drop in RUN lets the PLL relock by itself; no PLL reset here.
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
          if (loss_q != LOSS_MAX) begin
            loss_d = loss_q + LOSS_W'(1);
          end
        end
      end

      FAIL: begin
        state_d = FAIL;
      end

      default: begin
        state_d = PLL_RESET;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= PLL_RESET;
      cnt_q      <= '0;
      retry_q    <= '0;
      loss_q     <= '0;
      pll_rst_q  <= 1'b1;
      user_rst_q <= 1'b1;
      ready_q    <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      loss_q     <= loss_d;
      pll_rst_q  <= (state_d == PLL_RESET);
      user_rst_q <= (state_d != RUN);
      ready_q    <= (state_d == RUN);
      fail_q     <= (state_d == FAIL);
    end
  end

  assign bus.pll_rst   = pll_rst_q;
  assign bus.user_rst  = user_rst_q;
  assign bus.ready     = ready_q;
  assign bus.pll_fail  = fail_q;
  assign bus.retry_cnt = retry_q;
  assign bus.loss_cnt  = loss_q;

endmodule
